comparator_tree: RTL and testbench

- Parameterized magnitude/equality comparator for two WIDTH-bit operands.
- Outputs are equality, signed less-than (two's complement) and unsigned less-than.
- Built as a log2(WIDTH)-deep binary tree of compare nodes.
- Used in the integer ALU/branch-compare datapath:
  - combinational outputs for same-cycle use;
  - registered copies for timing-relaxed consumers.

---
 rtl/comparator_tree_pkg.sv | 11 +
 rtl/comparator_tree_if.sv | 27 ++
 rtl/comparator_tree_node.sv | 14 +
 rtl/comparator_tree.sv | 84 ++++++++
 tb/tb_comparator_tree.sv | 121 ++++++++++++
 5 files changed

// File: rtl/comparator_tree_pkg.sv
// rtl/comparator_tree_pkg.sv - shared width default and tree node type for comparator_tree
package comparator_tree_pkg;

    localparam int CMP_DEFAULT_WIDTH = 128;

    typedef struct packed {
        logic eq;
        logic lt;
    } cmp_node_t;

endpackage

// File: rtl/comparator_tree_if.sv
// rtl/comparator_tree_if.sv - operand/result bundle for comparator_tree (COMPARATOR_TREE_GE_EN adds GE/GEu)
interface comparator_tree_if
    import comparator_tree_pkg::*;
#(
    parameter int WIDTH = CMP_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             EQ;
    logic             LT;
    logic             LTu;
    logic             EQ_r;
    logic             LT_r;
    logic             LTu_r;
`ifdef COMPARATOR_TREE_GE_EN
    logic             GE;
    logic             GEu;

    modport master (output op1, op2, input EQ, LT, LTu, EQ_r, LT_r, LTu_r, GE, GEu);
    modport slave  (input op1, op2, output EQ, LT, LTu, EQ_r, LT_r, LTu_r, GE, GEu);
`else
    modport master (output op1, op2, input EQ, LT, LTu, EQ_r, LT_r, LTu_r);
    modport slave  (input op1, op2, output EQ, LT, LTu, EQ_r, LT_r, LTu_r);
`endif

endinterface

// File: rtl/comparator_tree_node.sv
// rtl/comparator_tree_node.sv - merges a more-significant and less-significant compare result
module cmp_tree_node
    import comparator_tree_pkg::*;
(
    input  cmp_node_t hi_i,
    input  cmp_node_t lo_i,
    output cmp_node_t out_o
);

    // The low half only decides the ordering when the high half is equal.
    assign out_o.eq = hi_i.eq & lo_i.eq;
    assign out_o.lt = hi_i.lt | (hi_i.eq & lo_i.lt);

endmodule

// File: rtl/comparator_tree.sv
// rtl/comparator_tree.sv - log2(WIDTH)-deep eq/lt compare tree with registered copies
// Optional GE/GEu outputs are enabled with COMPARATOR_TREE_GE_EN.
module comparator_tree
    import comparator_tree_pkg::*;
#(
    parameter int WIDTH = CMP_DEFAULT_WIDTH
)(
    input  logic                clk,
    input  logic                reset_n,
    comparator_tree_if.slave    cmp
);

    localparam int DEPTH = $clog2(WIDTH);

    cmp_node_t leaf [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        assign leaf[i].eq = ~(cmp.op1[i] ^ cmp.op2[i]);
        assign leaf[i].lt = ~cmp.op1[i] & cmp.op2[i];
    end

    // Level l holds WIDTH>>l nodes; node k spans bits of children 2k+1 (high) and 2k (low).
    for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        cmp_node_t nodes [N];
        for (genvar k = 0; k < N; k++) begin : g_node
            if (l == 1) begin : g_from_leaf
                cmp_tree_node u_node (
                    .hi_i  (leaf[2*k+1]),
                    .lo_i  (leaf[2*k]),
                    .out_o (nodes[k])
                );
            end else begin : g_from_prev
                cmp_tree_node u_node (
                    .hi_i  (g_lvl[l-1].nodes[2*k+1]),
                    .lo_i  (g_lvl[l-1].nodes[2*k]),
                    .out_o (nodes[k])
                );
            end
        end
    end

    logic eq_c;
    logic ltu_c;
    logic lt_c;

    assign eq_c  = g_lvl[DEPTH].nodes[0].eq;
    assign ltu_c = g_lvl[DEPTH].nodes[0].lt;
    // Differing sign bits: the operand with the sign bit set is the smaller one.
    assign lt_c  = (cmp.op1[WIDTH-1] != cmp.op2[WIDTH-1]) ? cmp.op1[WIDTH-1] : ltu_c;

    assign cmp.EQ  = eq_c;
    assign cmp.LT  = lt_c;
    assign cmp.LTu = ltu_c;

`ifdef COMPARATOR_TREE_GE_EN
    assign cmp.GE  = ~lt_c;
    assign cmp.GEu = ~ltu_c;
`endif

    logic eq_d, lt_d, ltu_d;
    logic eq_q, lt_q, ltu_q;

    assign eq_d  = eq_c;
    assign lt_d  = lt_c;
    assign ltu_d = ltu_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            ltu_q <= 1'b0;
        end else begin
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            ltu_q <= ltu_d;
        end
    end

    assign cmp.EQ_r  = eq_q;
    assign cmp.LT_r  = lt_q;
    assign cmp.LTu_r = ltu_q;

endmodule

// File: tb/tb_comparator_tree.sv
// tb/tb_comparator_tree.sv - scoreboard bench for comparator_tree (COMPARATOR_TREE_GE_EN checks GE/GEu)
module tb_comparator_tree;

    localparam int W = 128;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [2:0] exp_q [$];

    comparator_tree_if #(.WIDTH(W)) bus ();

    comparator_tree #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cmp     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b (eq,lt,ltu)", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a == b, $signed(a) < $signed(b), a < b};
    endfunction

    task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2:0] e;
        logic [2:0] r;
        @(posedge clk);
        #1;
        bus.op1 = a;
        bus.op2 = b;
        e = model(a, b);
        exp_q.push_back(e);
        @(negedge clk);
        check_val({tag, "_comb"}, {bus.EQ, bus.LT, bus.LTu}, e);
`ifdef COMPARATOR_TREE_GE_EN
        check_val({tag, "_ge"}, {1'b0, bus.GE, bus.GEu}, {1'b0, ~e[1], ~e[0]});
`endif
        if (exp_q.size() > 1) begin
            r = exp_q.pop_front();
            check_val({tag, "_reg"}, {bus.EQ_r, bus.LT_r, bus.LTu_r}, r);
        end
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] ones;
        logic [W-1:0] minneg;
        logic [W-1:0] a;
        logic [W-1:0] b;

        pat    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        ones   = '1;
        minneg = {1'b1, {(W-1){1'b0}}};

        bus.op1 = '0;
        bus.op2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_regs", {bus.EQ_r, bus.LT_r, bus.LTu_r}, 3'b000);
        check_val("reset_comb", {bus.EQ, bus.LT, bus.LTu}, 3'b100);
        reset_n = 1'b1;

        apply("identical", pat, pat);
        apply("zero_vs_ones", '0, ones);
        apply("ones_vs_zero", ones, '0);
        apply("minneg_vs_maxpos", minneg, ~minneg);
        apply("maxpos_vs_minneg", ~minneg, minneg);
        apply("lsb_2_3", {pat[W-1:4], 4'h2}, {pat[W-1:4], 4'h3});
        apply("lsb_3_2", {pat[W-1:4], 4'h3}, {pat[W-1:4], 4'h2});
        apply("lsb_neg", {ones[W-1:1], 1'b0}, ones);

        // Mid-cycle reset while the registered equality flag is high.
        apply("pre_reset", pat, pat);
        @(posedge clk);
        #2;
        check_val("reg_before_reset", {bus.EQ_r, bus.LT_r, bus.LTu_r}, 3'b100);
        reset_n = 1'b0;
        #1;
        check_val("reg_async_clear", {bus.EQ_r, bus.LT_r, bus.LTu_r}, 3'b000);
        check_val("comb_in_reset", {bus.EQ, bus.LT, bus.LTu}, 3'b100);
        @(posedge clk);
        #1;
        check_val("reg_held_reset", {bus.EQ_r, bus.LT_r, bus.LTu_r}, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("reg_after_release", {bus.EQ_r, bus.LT_r, bus.LTu_r}, 3'b000);
        exp_q.delete();
        exp_q.push_back(model(pat, pat));

        apply("post_reset", '0, ones);

        for (int n = 0; n < 2000; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (128'd1 << $urandom_range(0, W - 1));
                2: b = {a[W-1:8], b[7:0]};
                default: ;
            endcase
            apply("random", a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
